// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU load/store
// unit (requester 0) and the debug/program loader (requester 1). Grants at most
// one request per cycle, rejects misaligned/out-of-range accesses, and returns a
// registered one-cycle-latency response to each requester.
// Optional feature: define DMEM_ARB_RR_EN for round-robin priority; otherwise
// requester 0 has fixed priority and no pointer register exists.
module dmem_arbiter #(
  parameter int unsigned ADDR_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [31:0] req0_address,
  input  logic [31:0] req0_wdata,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  output logic        resp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [31:0] req1_address,
  input  logic [31:0] req1_wdata,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic        resp1_err,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] AddrLimit = 32'(4 * ADDR_WORDS);

  logic        grant0, grant1, any_grant, prefer1;
  logic        sel_write, sel_err, sel_good;
  logic [31:0] sel_addr, sel_wdata, load_data;

  logic        resp0_valid_q, resp1_valid_q;
  logic        resp0_err_q, resp1_err_q;
  logic [31:0] resp0_rdata_q, resp1_rdata_q;

`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Priority pointer: after a grant, favour the other requester; hold when idle.
  always_comb begin
    ptr_d = ptr_q;
    if (grant0) begin
      ptr_d = 1'b1;
    end else if (grant1) begin
      ptr_d = 1'b0;
    end
  end

  // Pointer register, reset to favour requester 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign prefer1 = ptr_q;
`else
  assign prefer1 = 1'b0;
`endif

  // Grant decision; nothing is granted while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        grant1 = prefer1;
        grant0 = !prefer1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign any_grant  = grant0 | grant1;

  // Select the granted request and classify it; memory sees only good accesses.
  always_comb begin
    sel_write = grant1 ? req1_write   : req0_write;
    sel_addr  = grant1 ? req1_address : req0_address;
    sel_wdata = grant1 ? req1_wdata   : req0_wdata;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= AddrLimit);
    sel_good  = any_grant && !sel_err;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    if (sel_good) begin
      mem_write_enable = sel_write;
      mem_address      = sel_addr;
      mem_write_data   = sel_wdata;
    end
    load_data = (sel_good && !sel_write) ? mem_read_data : '0;
  end

  // Response registers; data/err are only refreshed on a transfer for that port.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_err_q   <= 1'b0;
      resp1_err_q   <= 1'b0;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
    end else begin
      resp0_valid_q <= grant0;
      resp1_valid_q <= grant1;
      if (grant0) begin
        resp0_err_q   <= sel_err;
        resp0_rdata_q <= load_data;
      end
      if (grant1) begin
        resp1_err_q   <= sel_err;
        resp1_rdata_q <= load_data;
      end
    end
  end

  // A reset arriving the cycle after a transfer drops the pending response.
  assign resp0_valid = resp0_valid_q && !reset;
  assign resp1_valid = resp1_valid_q && !reset;
  assign resp0_err   = resp0_err_q;
  assign resp1_err   = resp1_err_q;
  assign resp0_rdata = resp0_rdata_q;
  assign resp1_rdata = resp1_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port, word-addressed data memory (64 x 32-bit, asynchronous read, synchronous write) between two requesters: requester 0 is the CPU load/store unit, requester 1 is the debug/program loader. It sits directly in front of the memory and owns its `write_enable`, `address` and `write_data` inputs. It also registers the read data into a one-cycle-latency response per requester. It rejects misaligned or out-of-range accesses before they reach the memory.

## Interface
Parameters:
- `ADDR_WORDS`, 64: number of memory words; valid byte addresses are 0 to 4*ADDR_WORDS-1.

Ports:
- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `req0_valid`  in  1  requester 0 has a transaction
- `req0_ready`  out  1  requester 0 transaction accepted this cycle
- `req0_write`  in  1  1 = store, 0 = load
- `req0_address`  in  32  byte address
- `req0_wdata`  in  32  store data
- `resp0_valid`  out  1  response for requester 0
- `resp0_rdata`  out  32  load data (0 for stores/errors)
- `resp0_err`  out  1  accepted transaction was rejected
- `req1_*` / `resp1_*`: identical set for requester 1
- `mem_write_enable`  out  1  to memory write enable
- `mem_address`  out  32  to memory byte address
- `mem_write_data`  out  32  to memory write data
- `mem_read_data`  in  32  from memory (asynchronous read)

## Operation
- Each cycle, at most one request is granted: `reqN_ready` = grant N, computed combinationally from both valids and the priority pointer. A transfer occurs when `valid && ready`.
- Requesters must hold the address, data and write signals stable while valid is high and not ready. Valid must not depend on ready.
- Only one requester valid: it is granted.
- Both requesters valid: the requester indicated by the priority pointer wins.
- Pointer update: after each grant, the pointer points at the other requester. With no grant, the pointer holds.
- Error check on the granted request: `address[1:0] != 0` or `address >= 4*ADDR_WORDS` means error.
- Memory drive, granted and no error:
  - `mem_address` = granted address.
  - `mem_write_data` = granted wdata.
  - `mem_write_enable` = granted write.
- Memory drive, no grant or error: `mem_write_enable` = 0, `mem_address` = 0, `mem_write_data` = 0.
- Response register, per requester, captured at the edge ending the transfer cycle:
  - `resp_valid` = 1.
  - `resp_err` = error.
  - `resp_rdata` = `mem_read_data` for a good load, otherwise 0.
- Responses have no backpressure. The requester must accept `resp_valid` whenever it is asserted.

## Timing
- Accept-to-response latency is exactly 1 cycle. `resp_valid` pulses for 1 cycle per accepted transaction.
- Store data is written into memory at the same edge that ends the transfer cycle.
- Throughput is 1 transaction per cycle total. Back-to-back grants to the same requester are allowed only when the other requester is not valid.
- Two valid requests cause alternating grants: N, M, N, M...
- Load following a store to the same address: the load's response returns the new data, because the write lands before the load's address phase.
- Reset values:
  - All `reqN_ready`, `respN_valid` and `respN_err` = 0.
  - `respN_rdata` = 0.
  - `mem_write_enable` = 0 and `mem_address` = 0.
  - Pointer = requester 0.
- During reset, no grants are issued and the memory is never written.
- Reset asserted in the cycle after a transfer: the pending response is dropped and `resp_valid` stays 0.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin priority pointer as described above.
- `DMEM_ARB_RR_EN` undefined: fixed priority. Requester 0 always wins a simultaneous request and the pointer register is not built. All other behaviour is identical.

## Test plan
- Single load: preload word 3 = 0xDEADBEEF; req0 loads address 0x0C. Required: `req0_ready`=1 that cycle; next cycle `resp0_valid`=1, `resp0_rdata`=0xDEADBEEF, `resp0_err`=0.
- Store then load: req1 stores 0x12345678 to 0x10, then loads 0x10 in the next cycle. Required: store response has `resp1_rdata`=0; load response has `resp1_rdata`=0x12345678.
- Contention, RR enabled: both requesters valid for 4 cycles from reset. Required: grants 0, 1, 0, 1. With the macro undefined: grants 0, 0, 0, 0 and req1 is never ready.
- Errors: req0 accesses 0x02 (store) and 0x100 (load) with `ADDR_WORDS`=64. Required: `mem_write_enable` stays 0; `resp0_err`=1 and `resp0_rdata`=0 for both; memory contents unchanged.
- Reset mid-operation: req0 load granted, then `reset` is asserted on the next cycle. Required: `resp0_valid` stays 0; `reset` held 2 cycles with both valids high produces no readies; after reset, pointer favours req0.
